// File: rtl/bubble_sort_pkg.sv
// bubble_sort_pkg: shared types and default sizes for the sorting engine.
// Provides the controller state enum and the default word width / depth.
package bubble_sort_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        WAIT,
        SEND
    } state_t;

    localparam int WORD_SIZE_DEF = 4;
    localparam int N_DEF         = 8;

endpackage

// File: rtl/bubble_sort_alternative_if.sv
// bubble_sort_alternative_if: command/status/data bundle of the sorter.
// master: drives Load/Sort/Send/Data_in, sees Ready/Busy/Waiting/Data_out.
// slave : the sorting engine side of the same signals.
interface bubble_sort_alternative_if
    import bubble_sort_pkg::*;
#(
    parameter int word_size = WORD_SIZE_DEF
);

    logic                 Load;
    logic                 Sort;
    logic                 Send;
    logic [word_size-1:0] Data_in;
    logic                 Ready;
    logic                 Busy;
    logic                 Waiting;
    logic [word_size-1:0] Data_out;

    modport master (
        output Load, Sort, Send, Data_in,
        input  Ready, Busy, Waiting, Data_out
    );

    modport slave (
        input  Load, Sort, Send, Data_in,
        output Ready, Busy, Waiting, Data_out
    );

endinterface

// File: rtl/sort_cmp_swap.sv
// sort_cmp_swap: one compare-swap cell of the transposition network.
// Ports: i_a/i_b (lower/upper index word), o_first/o_second (ordered pair).
// Macro BUBBLE_SORT_DESCENDING_EN selects descending order (else ascending).
module sort_cmp_swap #(
    parameter int word_size = 4
) (
    input  logic [word_size-1:0] i_a,
    input  logic [word_size-1:0] i_b,
    output logic [word_size-1:0] o_first,
    output logic [word_size-1:0] o_second
);

    logic w_swap;

`ifdef BUBBLE_SORT_DESCENDING_EN
    assign w_swap = (i_a < i_b);
`else
    assign w_swap = (i_a > i_b);
`endif

    assign o_first  = w_swap ? i_b : i_a;
    assign o_second = w_swap ? i_a : i_b;

endmodule

// File: rtl/bubble_sort_alternative.sv
// bubble_sort_alternative: serial-load, odd-even transposition sort, serial
// stream-out engine. Ports: clk, rst (sync, active high), bus (slave side of
// bubble_sort_alternative_if). Macro BUBBLE_SORT_DESCENDING_EN: descending.
module bubble_sort_alternative
    import bubble_sort_pkg::*;
#(
    parameter int word_size = WORD_SIZE_DEF,
    parameter int N         = N_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    bubble_sort_alternative_if.slave     bus
);

    // Counter must reach N during SEND to mark the end of the stream.
    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [word_size-1:0] r_dout;
    logic [word_size-1:0] r_arr    [N];
    logic [word_size-1:0] w_sorted [N];
    logic [word_size-1:0] w_first  [N-1];
    logic [word_size-1:0] w_second [N-1];

    for (genvar k = 0; k < N - 1; k++) begin : g_cell
        sort_cmp_swap #(
            .word_size (word_size)
        ) u_cell (
            .i_a      (r_arr[k]),
            .i_b      (r_arr[k+1]),
            .o_first  (w_first[k]),
            .o_second (w_second[k])
        );
    end

    // Only cells whose lower index parity matches the phase parity are
    // applied; those pairs are disjoint so each word has one writer.
    always_comb begin
        w_sorted = r_arr;
        for (int k = 0; k < N - 1; k++) begin
            if (k[0] == r_cnt[0]) begin
                w_sorted[k]   = w_first[k];
                w_sorted[k+1] = w_second[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dout  <= '0;
            for (int i = 0; i < N; i++) begin
                r_arr[i] <= '0;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.Load) begin
                        for (int i = 0; i < N - 1; i++) begin
                            r_arr[i] <= r_arr[i+1];
                        end
                        r_arr[N-1] <= bus.Data_in;
                    end else if (bus.Sort) begin
                        r_state <= SORT;
                        r_cnt   <= '0;
                    end
                end
                SORT: begin
                    r_arr <= w_sorted;
                    if (r_cnt == CW'(N - 1)) begin
                        r_state <= WAIT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                WAIT: begin
                    if (bus.Send) begin
                        r_state <= SEND;
                        r_dout  <= r_arr[0];
                        r_cnt   <= CW'(1);
                    end
                end
                SEND: begin
                    if (r_cnt == CW'(N)) begin
                        r_state <= IDLE;
                        r_dout  <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_dout <= r_arr[r_cnt[IW-1:0]];
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_dout  <= '0;
                end
            endcase
        end
    end

    assign bus.Ready    = (r_state == IDLE);
    assign bus.Busy     = (r_state == SORT) || (r_state == SEND);
    assign bus.Waiting  = (r_state == WAIT);
    assign bus.Data_out = r_dout;

endmodule

// File: tb/tb_bubble_sort_alternative.sv
// tb_bubble_sort_alternative: directed scoreboard bench for the sorter.
// Expected streams are queued at Send time and checked by a monitor.
module tb_bubble_sort_alternative;

    localparam int WS = 4;
    localparam int N  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    int unsigned exp_q [$];

    bubble_sort_alternative_if #(.word_size(WS)) bus ();

    bubble_sort_alternative #(
        .word_size (WS),
        .N         (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Vectors are written in ascending order; descending builds reverse them.
    task automatic push_exp(input int unsigned v [N]);
        for (int j = 0; j < N; j++) begin
`ifdef BUBBLE_SORT_DESCENDING_EN
            exp_q.push_back(v[N-1-j]);
`else
            exp_q.push_back(v[j]);
`endif
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, "_ready"}, int'(bus.Ready), 1);
        chk({name, "_busy"}, int'(bus.Busy), 0);
        chk({name, "_waiting"}, int'(bus.Waiting), 0);
        chk({name, "_dout"}, int'(bus.Data_out), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic load(input int unsigned w [$]);
        foreach (w[i]) begin
            bus.Load    = 1'b1;
            bus.Data_in = WS'(w[i]);
            @(negedge clk);
        end
        bus.Load    = 1'b0;
        bus.Data_in = '0;
    endtask

    task automatic do_sort(input int hold);
        int n;
        bus.Sort = 1'b1;
        repeat (hold) @(negedge clk);
        bus.Sort = 1'b0;
        n = 0;
        while (bus.Busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("sort_busy_cycles", n, N - hold + 1);
        chk("sort_waiting", int'(bus.Waiting), 1);
    endtask

    task automatic do_send(input int hold, input int unsigned v [N]);
        int n;
        push_exp(v);
        bus.Send = 1'b1;
        repeat (hold) @(negedge clk);
        bus.Send = 1'b0;
        n = 0;
        while (!bus.Ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("send_busy_cycles", n, N - hold + 1);
        chk("send_end_ready", int'(bus.Ready), 1);
        chk("send_end_dout", int'(bus.Data_out), 0);
    endtask

    // Monitor: a stream starts on the first Busy cycle right after WAIT.
    initial begin
        logic pw;
        int unsigned e;
        pw = 1'b0;
        forever begin
            @(negedge clk);
            if (pw && bus.Busy) begin
                for (int j = 0; j < N; j++) begin
                    if (j > 0) @(negedge clk);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected got=%0d exp=none",
                                 bus.Data_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("stream_word%0d", j),
                            int'(bus.Data_out), int'(e));
                    end
                end
            end
            pw = bus.Waiting;
        end
    end

    initial begin
        int n;
        bus.Load    = 1'b0;
        bus.Sort    = 1'b0;
        bus.Send    = 1'b0;
        bus.Data_in = '0;

        do_reset();
        check_idle("reset");

        // Twelve loads: only the last eight survive.
        load('{0, 0, 0, 0, 6, 1, 3, 5, 7, 8, 2, 10});
        do_sort(3);
        do_send(2, '{1, 2, 3, 5, 6, 7, 8, 10});

        // Single-cycle Sort and Send pulses.
        load('{11, 13, 1, 5, 9, 4, 3, 8});
        do_sort(1);
        do_send(1, '{1, 3, 4, 5, 8, 9, 11, 13});

        // Partial load after reset: zeros take part in the sort.
        do_reset();
        load('{9, 2, 7});
        do_sort(1);
        do_send(1, '{0, 0, 0, 0, 0, 2, 7, 9});

        // Load wins over Sort; array becomes 0,0,0,0,2,7,9,4.
        bus.Load    = 1'b1;
        bus.Sort    = 1'b1;
        bus.Data_in = WS'(4);
        @(negedge clk);
        bus.Load    = 1'b0;
        bus.Sort    = 1'b0;
        bus.Data_in = '0;
        chk("load_prio_ready", int'(bus.Ready), 1);
        chk("load_prio_busy", int'(bus.Busy), 0);

        // Send in IDLE is ignored.
        bus.Send = 1'b1;
        @(negedge clk);
        bus.Send = 1'b0;
        chk("idle_send_ready", int'(bus.Ready), 1);
        chk("idle_send_dout", int'(bus.Data_out), 0);

        // Send during SORT is ignored.
        bus.Sort = 1'b1;
        @(negedge clk);
        bus.Sort = 1'b0;
        bus.Send = 1'b1;
        @(negedge clk);
        bus.Send = 1'b0;
        chk("sort_send_busy", int'(bus.Busy), 1);
        chk("sort_send_dout", int'(bus.Data_out), 0);
        n = 0;
        while (!bus.Waiting && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("sort_send_waiting", int'(bus.Waiting), 1);
        @(negedge clk);
        chk("wait_holds", int'(bus.Waiting), 1);
        chk("wait_dout", int'(bus.Data_out), 0);
        do_send(1, '{0, 0, 0, 0, 2, 4, 7, 9});

        // Reset lands on the phase-3 edge of a sort.
        load('{6, 1, 3, 5, 7, 8, 2, 10});
        bus.Sort = 1'b1;
        @(negedge clk);
        bus.Sort = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", int'(bus.Busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_sort_rst");
        do_sort(1);
        do_send(1, '{0, 0, 0, 0, 0, 0, 0, 0});

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
